bank_register_mp: RTL and testbench

Parametrised successor of the ID-stage register bank.
- NB_READ independent registered read ports with write-through bypass; one pipeline write port; one explicit init port.
- Built-in debug dump sequencer streams the whole bank to the Debug Unit over a valid/ready handshake.
- Sits in b_ID between the decoder (read addresses) and WB (write-back).

---
 rtl/bank_register_mp.sv | 162 ++++++++++++++++
 tb/tb_bank_register_mp.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_register_mp.sv
// Multi-port register bank with write-through bypass and a valid/ready debug dump sequencer.
// Define ZERO_REG_EN to hardwire register 0 to zero.
module bank_register_mp #(
   parameter int unsigned DATA_SIZE  = 32,
   parameter int unsigned ADDR_SIZE  = 5,
   parameter int unsigned BANK_DEPTH = 32,
   parameter int unsigned NB_READ    = 2
) (
   input  logic                           i_clock,
   input  logic                           i_reset,
   input  logic                           i_enable,
   input  logic                           i_reg_write,
   input  logic [ADDR_SIZE-1:0]           i_write_reg,
   input  logic [DATA_SIZE-1:0]           i_write_data,
   input  logic [NB_READ*ADDR_SIZE-1:0]   i_read_addr,
   output logic [NB_READ*DATA_SIZE-1:0]   o_read_data,
   input  logic                           i_init_enable,
   input  logic [ADDR_SIZE-1:0]           i_init_addr,
   input  logic [DATA_SIZE-1:0]           i_init_data,
   input  logic                           i_dump_start,
   input  logic                           i_dump_ready,
   output logic                           o_dump_valid,
   output logic [ADDR_SIZE-1:0]           o_dump_addr,
   output logic [DATA_SIZE-1:0]           o_dump_data,
   output logic                           o_dump_done,
   output logic                           o_busy
);

`ifdef ZERO_REG_EN
   localparam bit ZERO_REG = 1'b1;
`else
   localparam bit ZERO_REG = 1'b0;
`endif

   localparam int unsigned IDX_W = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
   localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(BANK_DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      DONE
   } dump_state_e;

   logic [DATA_SIZE-1:0]         regs [BANK_DEPTH];
   logic [NB_READ*DATA_SIZE-1:0] read_data;
   logic [NB_READ*DATA_SIZE-1:0] read_next;

   dump_state_e                  state;
   dump_state_e                  state_next;
   logic [ADDR_SIZE-1:0]         dump_addr;
   logic [ADDR_SIZE-1:0]         dump_addr_next;
   logic [DATA_SIZE-1:0]         dump_data;
   logic [DATA_SIZE-1:0]         dump_data_next;

   function automatic logic [IDX_W-1:0] idx(input logic [ADDR_SIZE-1:0] addr);
      return IDX_W'(addr);
   endfunction

   // Backed by real storage: in range and not the hardwired zero register.
   function automatic logic writable(input logic [ADDR_SIZE-1:0] addr);
      logic [31:0] wide;
      wide = 32'(addr);
      return (wide < BANK_DEPTH) && !(ZERO_REG && (addr == '0));
   endfunction

   // Storage: init port has priority over the pipeline write-back.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         regs <= '{default: '0};
      end else if (i_init_enable) begin
         if (writable(i_init_addr)) begin
            regs[idx(i_init_addr)] <= i_init_data;
         end
      end else if (i_enable && i_reg_write && writable(i_write_reg)) begin
         regs[idx(i_write_reg)] <= i_write_data;
      end
   end

   always_comb begin
      logic [ADDR_SIZE-1:0] raddr;
      raddr     = '0;
      read_next = '0;
      for (int k = 0; k < NB_READ; k++) begin
         raddr = i_read_addr[k*ADDR_SIZE +: ADDR_SIZE];
         if (writable(raddr)) begin
            if (i_reg_write && (raddr == i_write_reg)) begin
               read_next[k*DATA_SIZE +: DATA_SIZE] = i_write_data;
            end else begin
               read_next[k*DATA_SIZE +: DATA_SIZE] = regs[idx(raddr)];
            end
         end
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         read_data <= '0;
      end else if (i_enable && !i_init_enable) begin
         read_data <= read_next;
      end
   end

   assign o_read_data = read_data;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state     <= IDLE;
         dump_addr <= '0;
         dump_data <= '0;
      end else begin
         state     <= state_next;
         dump_addr <= dump_addr_next;
         dump_data <= dump_data_next;
      end
   end

   always_comb begin
      logic load;
      load           = 1'b0;
      state_next     = state;
      dump_addr_next = dump_addr;
      dump_data_next = dump_data;
      unique case (state)
         IDLE: begin
            if (i_dump_start) begin
               state_next     = SEND;
               dump_addr_next = '0;
               load           = 1'b1;
            end
         end
         SEND: begin
            if (i_dump_ready) begin
               if (dump_addr == LAST_ADDR) begin
                  state_next = DONE;
               end else begin
                  dump_addr_next = dump_addr + ADDR_SIZE'(1);
                  load           = 1'b1;
               end
            end
         end
         DONE: begin
            state_next     = IDLE;
            dump_addr_next = '0;
         end
         default: begin
            state_next     = IDLE;
            dump_addr_next = '0;
         end
      endcase
      // Word is captured once when presented, so later writes do not disturb it.
      if (load) begin
         dump_data_next = writable(dump_addr_next) ? regs[idx(dump_addr_next)] : '0;
      end
   end

   assign o_dump_valid = (state == SEND);
   assign o_dump_done  = (state == DONE);
   assign o_busy       = (state != IDLE);
   assign o_dump_addr  = dump_addr;
   assign o_dump_data  = dump_data;

endmodule

// File: tb/tb_bank_register_mp.sv
// Scoreboard bench for bank_register_mp: stimulus queues expectations, a negedge monitor checks.
module tb_bank_register_mp;

`ifdef ZERO_REG_EN
   localparam bit Z = 1'b1;
`else
   localparam bit Z = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_enable;
   logic        i_reg_write;
   logic [4:0]  i_write_reg;
   logic [31:0] i_write_data;
   logic [9:0]  i_read_addr;
   logic [63:0] o_read_data;
   logic        i_init_enable;
   logic [4:0]  i_init_addr;
   logic [31:0] i_init_data;
   logic        i_dump_start;
   logic        i_dump_ready;
   logic        o_dump_valid;
   logic [4:0]  o_dump_addr;
   logic [31:0] o_dump_data;
   logic        o_dump_done;
   logic        o_busy;

   bank_register_mp dut (
      .i_clock      (clk),
      .i_reset      (i_reset),
      .i_enable     (i_enable),
      .i_reg_write  (i_reg_write),
      .i_write_reg  (i_write_reg),
      .i_write_data (i_write_data),
      .i_read_addr  (i_read_addr),
      .o_read_data  (o_read_data),
      .i_init_enable(i_init_enable),
      .i_init_addr  (i_init_addr),
      .i_init_data  (i_init_data),
      .i_dump_start (i_dump_start),
      .i_dump_ready (i_dump_ready),
      .o_dump_valid (o_dump_valid),
      .o_dump_addr  (o_dump_addr),
      .o_dump_data  (o_dump_data),
      .o_dump_done  (o_dump_done),
      .o_busy       (o_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      int          kind;
      logic [63:0] exp;
      string       name;
   } chk_t;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } dump_t;

   chk_t  chk_q[$];
   dump_t dump_q[$];

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;
   int done_count = 0;
   bit done_seen = 1'b0;
   bit hold_pending = 1'b0;
   logic [4:0]  hold_addr;
   logic [31:0] hold_data;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expectation due at the negedge after 'delay' more rising edges.
   task automatic expect_at(input int delay, input int kind, input logic [63:0] exp,
                            input string name);
      chk_t e;
      e.due  = cyc + delay;
      e.kind = kind;
      e.exp  = exp;
      e.name = name;
      chk_q.push_back(e);
   endtask

   task automatic exp_rd(input logic [31:0] p1, input logic [31:0] p0, input string name);
      expect_at(1, 0, {p1, p0}, name);
   endtask

   task automatic push_dump(input logic [4:0] addr, input logic [31:0] data);
      dump_t d;
      d.addr = addr;
      d.data = data;
      dump_q.push_back(d);
   endtask

   task automatic set_rd(input logic [4:0] p0, input logic [4:0] p1);
      i_read_addr = {p1, p0};
   endtask

   task automatic init_write(input logic [4:0] addr, input logic [31:0] data);
      i_init_enable = 1'b1;
      i_init_addr   = addr;
      i_init_data   = data;
      tick();
      i_init_enable = 1'b0;
   endtask

   function automatic logic [31:0] r0(input logic [31:0] v);
      return Z ? 32'h0 : v;
   endfunction

   // Monitor: timed checks plus dump-handshake scoreboard.
   always @(negedge clk) begin
      logic [63:0] act;
      dump_t d;
      while (chk_q.size() > 0 && chk_q[0].due <= cyc) begin
         chk_t e;
         e = chk_q.pop_front();
         case (e.kind)
            0:       act = o_read_data;
            1:       act = 64'(o_busy);
            2:       act = 64'(o_dump_valid);
            3:       act = 64'(o_dump_addr);
            default: act = 64'(o_dump_data);
         endcase
         check(e.name, act, e.exp);
      end
      if (i_reset && o_dump_valid) begin
         if (hold_pending) begin
            check("dump_hold_stable", {27'h0, o_dump_addr, o_dump_data},
                  {27'h0, hold_addr, hold_data});
         end
         if (i_dump_ready) begin
            if (dump_q.size() == 0) begin
               check("dump_unexpected_word", {27'h0, o_dump_addr, o_dump_data}, 64'hx);
            end else begin
               d = dump_q.pop_front();
               check("dump_word", {27'h0, o_dump_addr, o_dump_data}, {27'h0, d.addr, d.data});
            end
         end
         hold_pending = !i_dump_ready;
         hold_addr    = o_dump_addr;
         hold_data    = o_dump_data;
      end else begin
         hold_pending = 1'b0;
      end
      if (o_dump_done) begin
         done_count++;
         done_seen = 1'b1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      i_reset = 1'b0;
      i_enable = 1'b0;
      i_reg_write = 1'b0;
      i_write_reg = '0;
      i_write_data = '0;
      i_read_addr = '0;
      i_init_enable = 1'b0;
      i_init_addr = '0;
      i_init_data = '0;
      i_dump_start = 1'b0;
      i_dump_ready = 1'b0;
      repeat (2) tick();

      expect_at(0, 0, 64'h0, "reset_read");
      expect_at(0, 1, 64'h0, "reset_busy");
      expect_at(0, 2, 64'h0, "reset_valid");
      expect_at(0, 3, 64'h0, "reset_dump_addr");
      expect_at(0, 4, 64'h0, "reset_dump_data");
      tick();
      i_reset = 1'b1;

      // Preload then async reset mid-dump.
      init_write(5'd3, 32'hDEADBEEF);
      i_enable = 1'b1;
      set_rd(5'd3, 5'd0);
      exp_rd(32'h0, 32'hDEADBEEF, "read_reg3");
      tick();
      i_enable = 1'b0;
      set_rd(5'd1, 5'd1);
      exp_rd(32'h0, 32'hDEADBEEF, "hold_disabled");
      tick();
      i_dump_start = 1'b1;
      tick();
      i_dump_start = 1'b0;
      expect_at(0, 1, 64'h1, "busy_in_dump");
      expect_at(0, 2, 64'h1, "valid_in_dump");
      tick();
      i_enable = 1'b1;
      set_rd(5'd3, 5'd3);
      #2;
      i_reset = 1'b0;
      expect_at(0, 0, 64'h0, "async_reset_read");
      expect_at(0, 1, 64'h0, "async_reset_busy");
      expect_at(0, 2, 64'h0, "async_reset_valid");
      @(posedge clk);
      #1;
      i_reset = 1'b1;
      exp_rd(32'h0, 32'h0, "reg3_cleared");
      tick();

      // Read and bypass.
      init_write(5'd6, 32'hA5);
      i_enable = 1'b1;
      i_reg_write = 1'b1;
      i_write_reg = 5'd5;
      i_write_data = 32'h12345678;
      set_rd(5'd5, 5'd5);
      exp_rd(32'h12345678, 32'h12345678, "bypass_both");
      tick();
      i_reg_write = 1'b0;
      set_rd(5'd5, 5'd6);
      exp_rd(32'hA5, 32'h12345678, "read_array");
      tick();

      // Init priority and enable hold.
      i_init_enable = 1'b1;
      i_init_addr = 5'd7;
      i_init_data = 32'h11;
      i_reg_write = 1'b1;
      i_write_reg = 5'd7;
      i_write_data = 32'h22;
      set_rd(5'd7, 5'd7);
      exp_rd(32'hA5, 32'h12345678, "init_holds_reads");
      tick();
      i_init_enable = 1'b0;
      i_reg_write = 1'b0;
      exp_rd(32'h11, 32'h11, "init_wins");
      tick();
      i_enable = 1'b0;
      i_reg_write = 1'b1;
      i_write_reg = 5'd5;
      i_write_data = 32'h99;
      set_rd(5'd5, 5'd6);
      for (int i = 0; i < 5; i++) begin
         exp_rd(32'h11, 32'h11, "enable_hold");
         tick();
      end
      i_reg_write = 1'b0;
      i_enable = 1'b1;
      exp_rd(32'hA5, 32'h12345678, "wb_gated_by_enable");
      tick();

      // Register 0 behaviour.
      i_reg_write = 1'b1;
      i_write_reg = 5'd0;
      i_write_data = 32'hFFFF;
      set_rd(5'd0, 5'd0);
      exp_rd(r0(32'hFFFF), r0(32'hFFFF), "zero_bypass");
      tick();
      i_reg_write = 1'b0;
      exp_rd(r0(32'hFFFF), r0(32'hFFFF), "zero_wb_write");
      tick();
      init_write(5'd0, 32'hABCD);
      exp_rd(r0(32'hABCD), r0(32'hABCD), "zero_init_write");
      tick();
      i_enable = 1'b0;

      // Dump with backpressure and a concurrent write ahead of the sequencer.
      for (int k = 0; k < 32; k++) init_write(5'(k), 32'h100 + 32'(k));
      for (int k = 0; k < 32; k++) begin
         if (k == 0) push_dump(5'd0, r0(32'h100));
         else if (k == 20) push_dump(5'd20, 32'hCAFE);
         else push_dump(5'(k), 32'h100 + 32'(k));
      end
      done_seen = 1'b0;
      i_dump_start = 1'b1;
      tick();
      i_dump_start = 1'b0;
      for (int j = 0; j < 300 && !done_seen; j++) begin
         i_dump_ready = (j % 3 == 0);
         i_dump_start = (j >= 3 && j < 60);
         if (j == 5) begin
            i_enable = 1'b1;
            i_reg_write = 1'b1;
            i_write_reg = 5'd20;
            i_write_data = 32'hCAFE;
         end else begin
            i_enable = 1'b0;
            i_reg_write = 1'b0;
         end
         tick();
      end
      i_dump_ready = 1'b0;
      i_dump_start = 1'b0;
      check("dump1_completed", 64'(done_seen), 64'h1);
      check("dump1_words_left", 64'(dump_q.size()), 64'h0);
      expect_at(0, 1, 64'h0, "idle_busy");
      expect_at(0, 2, 64'h0, "idle_valid");
      expect_at(0, 3, 64'h0, "idle_dump_addr");
      tick();

      // Reset during dump at address 10, then restart.
      for (int k = 0; k < 10; k++) begin
         push_dump(5'(k), (k == 0) ? r0(32'h100) : 32'h100 + 32'(k));
      end
      done_seen = 1'b0;
      i_dump_ready = 1'b1;
      i_dump_start = 1'b1;
      tick();
      i_dump_start = 1'b0;
      for (int j = 0; j < 50 && o_dump_addr != 5'd10; j++) tick();
      #2;
      i_reset = 1'b0;
      expect_at(0, 2, 64'h0, "abort_valid");
      expect_at(0, 1, 64'h0, "abort_busy");
      expect_at(0, 3, 64'h0, "abort_dump_addr");
      @(posedge clk);
      #1;
      i_reset = 1'b1;
      check("abort_words_left", 64'(dump_q.size()), 64'h0);
      check("abort_no_done", 64'(done_seen), 64'h0);

      for (int k = 0; k < 32; k++) push_dump(5'(k), 32'h0);
      i_dump_start = 1'b1;
      tick();
      i_dump_start = 1'b0;
      for (int j = 0; j < 100 && !done_seen; j++) tick();
      i_dump_ready = 1'b0;
      check("dump2_completed", 64'(done_seen), 64'h1);
      check("dump2_words_left", 64'(dump_q.size()), 64'h0);
      repeat (3) tick();
      check("done_pulse_count", 64'(done_count), 64'h2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
